// File: rtl/ascii_field_streamer.sv
// ascii_field_streamer
// Round-robin arbiter that shares one binary-to-ASCII path among NREQ debug
// requesters. Each grant captures a W-bit field and emits it as the text frame
//   'A'+k, ':', W bit characters MSB first ('1'/'0'), '\n'
// over a valid/ready byte stream. All outputs come straight from registers.
module ascii_field_streamer #(
  parameter int NREQ = 4,
  parameter int W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [7:0] CH_TAG0 = 8'h41;
  localparam logic [7:0] CH_SEP  = 8'h3A;
  localparam logic [7:0] CH_EOL  = 8'h0A;
  localparam logic [7:0] CH_IDLE = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TAG  = 3'd1,
    SEP  = 3'd2,
    BITS = 3'd3,
    EOL  = 3'd4
  } state_e;

  // ASCII character for one field bit
  function automatic logic [7:0] bit_char(input logic b);
    if (b) begin
      return 8'h31;
    end else begin
      return 8'h30;
    end
  endfunction

  // Tag character for a requester index
  function automatic logic [7:0] tag_char(input logic [PW-1:0] k);
    return CH_TAG0 + {{(8-PW){1'b0}}, k};
  endfunction

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;

  logic [W-1:0]      field_s [NREQ];
  logic              found_s;
  logic [PW-1:0]     win_s;
  logic [W-1:0]      shifted_s;
  logic              accept_s;

  // Unpack the flattened field bus into one entry per requester
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      field_s[k] = data[k*W +: W];
    end
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    logic [PW-1:0] idx_v;
    found_s = 1'b0;
    win_s   = ptr_q;
    idx_v   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_v = PW'((int'(ptr_q) + i) % NREQ);
      if (req[idx_v] && !found_s) begin
        found_s = 1'b1;
        win_s   = idx_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    accept_s   = tx_valid_q && tx_ready;
    shifted_s  = shift_q << 1;

    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d       = TAG;
          ptr_d         = win_s;
          shift_d       = field_s[win_s];
          cnt_d         = '0;
          ack_d[win_s]  = 1'b1;
          tx_data_d     = tag_char(win_s);
          tx_valid_d    = 1'b1;
          busy_d        = 1'b1;
        end else begin
          tx_data_d  = CH_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      TAG: begin
        if (accept_s) begin
          state_d   = SEP;
          tx_data_d = CH_SEP;
        end else begin
          state_d = TAG;
        end
      end
      SEP: begin
        if (accept_s) begin
          state_d   = BITS;
          cnt_d     = '0;
          tx_data_d = bit_char(shift_q[W-1]);
        end else begin
          state_d = SEP;
        end
      end
      BITS: begin
        if (accept_s) begin
          // Shift after every accepted bit so the MSB always holds the next one
          shift_d = shifted_s;
          if (cnt_q == CW'(W-1)) begin
            state_d   = EOL;
            tx_data_d = CH_EOL;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_data_d = bit_char(shifted_s[W-1]);
          end
        end else begin
          state_d = BITS;
        end
      end
      EOL: begin
        if (accept_s) begin
          state_d    = IDLE;
          tx_data_d  = CH_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end else begin
          state_d = EOL;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_data_d  = CH_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset drops any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NREQ-1);
      shift_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_data_q  <= CH_IDLE;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ascii_field_streamer.sv
// Directed bench for ascii_field_streamer with NREQ=4, W=3.
module tb_ascii_field_streamer;

  localparam int NREQ = 4;
  localparam int W    = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  int n_checks;
  int n_fail;

  ascii_field_streamer #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a presented byte with valid/busy high and no ack
  task automatic expect_byte(input string name, input logic [7:0] exp);
    n_checks++;
    if (tx_data !== exp || tx_valid !== 1'b1 || busy !== 1'b1 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s: tx_data=%h valid=%b busy=%b ack=%b, required tx_data=%h valid=1 busy=1 ack=0000",
               name, tx_data, tx_valid, busy, ack, exp);
    end
  endtask

  task automatic expect_idle(input string name);
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s: valid=%b busy=%b ack=%b, required valid=0 busy=0 ack=0000",
               name, tx_valid, busy, ack);
    end
  endtask

  task automatic expect_grant(input string name, input logic [3:0] exp_ack, input logic [7:0] exp_tag);
    n_checks++;
    if (ack !== exp_ack || tx_data !== exp_tag || tx_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ack=%b tx_data=%h valid=%b busy=%b, required ack=%b tx_data=%h valid=1 busy=1",
               name, ack, tx_data, tx_valid, busy, exp_ack, exp_tag);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    req      = '0;
    data     = '0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ack !== 4'b0000 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: ack=%b valid=%b data=%h busy=%b, required 0000 0 00 0",
               ack, tx_valid, tx_data, busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    test_reset();
    data[2:0] = 3'b101;
    req       = 4'b0001;
    step();
    expect_grant("single_grant", 4'b0001, 8'h41);
    req = 4'b0000;
    step(); expect_byte("single_sep",  8'h3A);
    step(); expect_byte("single_b2",   8'h31);
    step(); expect_byte("single_b1",   8'h30);
    step(); expect_byte("single_b0",   8'h31);
    step(); expect_byte("single_eol",  8'h0A);
    step(); expect_idle("single_done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    test_reset();
    req = 4'b1111;
    step();
    for (int f = 0; f < 5; f++) begin
      exp_ack = 4'b0001 << (f % 4);
      expect_grant($sformatf("rr_grant%0d", f), exp_ack, 8'h41 + 8'(f % 4));
      for (int j = 1; j < 6; j++) begin
        step();
        n_checks++;
        if (tx_valid !== 1'b1 || ack !== 4'b0000) begin
          n_fail++;
          $display("FAIL rr_frame%0d_byte%0d: valid=%b ack=%b, required valid=1 ack=0000",
                   f, j, tx_valid, ack);
        end
      end
      step();
      expect_idle($sformatf("rr_gap%0d", f));
      step();
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic [7:0] got [6];
    logic [7:0] exp_b [6];
    logic [3:0] pat;
    logic [7:0] prev_data;
    logic       stalled;
    int         nacc;
    exp_b = '{8'h43, 8'h3A, 8'h30, 8'h31, 8'h31, 8'h0A};
    pat   = 4'b1001;  // index 0..3 -> 1,0,0,1
    test_reset();
    data[8:6] = 3'b011;
    req       = 4'b0100;
    step();
    expect_grant("bp_grant", 4'b0100, 8'h43);
    req       = 4'b0000;
    nacc      = 0;
    stalled   = 1'b0;
    prev_data = 8'h00;
    for (int c = 0; c < 40 && nacc < 6; c++) begin
      tx_ready = pat[c % 4];
      if (stalled) begin
        n_checks++;
        if (tx_data !== prev_data || tx_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: tx_data=%h valid=%b, required tx_data=%h valid=1",
                   c, tx_data, tx_valid, prev_data);
        end
      end
      if (tx_valid && tx_ready) begin
        got[nacc] = tx_data;
        nacc++;
      end
      stalled   = tx_valid && !tx_ready;
      prev_data = tx_data;
      step();
    end
    tx_ready = 1'b1;
    n_checks++;
    if (nacc != 6) begin
      n_fail++;
      $display("FAIL bp_count: accepted %0d bytes, required 6", nacc);
    end
    for (int i = 0; i < nacc; i++) begin
      n_checks++;
      if (got[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL bp_byte%0d: accepted %h, required %h", i, got[i], exp_b[i]);
      end
    end
    expect_idle("bp_done");
  endtask

  task automatic test_capture_isolation();
    test_reset();
    data[5:3] = 3'b111;
    req       = 4'b0010;
    step();
    expect_grant("cap_grant", 4'b0010, 8'h42);
    data[5:3] = 3'b000;
    req       = 4'b0000;
    step(); expect_byte("cap_sep", 8'h3A);
    step(); expect_byte("cap_b2",  8'h31);
    step(); expect_byte("cap_b1",  8'h31);
    step(); expect_byte("cap_b0",  8'h31);
    step(); expect_byte("cap_eol", 8'h0A);
    step(); expect_idle("cap_done");
  endtask

  task automatic test_reset_mid_frame();
    test_reset();
    data      = '0;
    data[2:0] = 3'b101;
    req       = 4'b0001;
    step();
    expect_grant("rmf_grant", 4'b0001, 8'h41);
    req = 4'b0000;
    step(); expect_byte("rmf_sep", 8'h3A);
    step(); expect_byte("rmf_b2",  8'h31);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ack !== 4'b0000 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmf_async: ack=%b valid=%b data=%h busy=%b, required 0000 0 00 0",
               ack, tx_valid, tx_data, busy);
    end
    step();
    rst_n      = 1'b1;
    data[11:9] = 3'b110;
    req        = 4'b1000;
    step();
    expect_grant("rmf_grant3", 4'b1000, 8'h44);
    req = 4'b0000;
    step(); expect_byte("rmf3_sep", 8'h3A);
    step(); expect_byte("rmf3_b2",  8'h31);
    step(); expect_byte("rmf3_b1",  8'h31);
    step(); expect_byte("rmf3_b0",  8'h30);
    step(); expect_byte("rmf3_eol", 8'h0A);
    step(); expect_idle("rmf3_done");
  endtask

  task automatic test_withdrawn();
    int bad;
    test_reset();
    req = 4'b0001;
    step();
    expect_grant("wd_grant", 4'b0001, 8'h41);
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    step();
    req = 4'b0000;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (ack[2] === 1'b1 || (tx_valid === 1'b1 && tx_data === 8'h43)) begin
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wd_never_served: %0d cycles with ack[2] or tag 43, required 0", bad);
    end
    expect_idle("wd_idle");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = '0;
    data     = '0;
    tx_ready = 1'b1;
    test_single();
    test_round_robin();
    test_backpressure();
    test_capture_isolation();
    test_reset_mid_frame();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_field_streamer.md
# ascii_field_streamer

Round-robin controller that shares one binary-to-ASCII character path among several debug requesters and serializes each request as a short ASCII text frame on a byte stream with a valid/ready handshake. It sits between pipeline-stage debug taps (register indices, opcode fields, flags) and the board's text output, such as a UART transmitter or LCD writer. Each grant captures one W-bit field and emits it as readable characters, MSB first.

## Interface
- NREQ, 4, number of requesters (1..26)
- W, 3, field width in bits per requester (1..16)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request; held high until its ack
- data  in  NREQ*W  flattened fields; requester k at data[k*W +: W]
- ack  out  NREQ  one-cycle grant/capture pulse, one-hot or zero
- tx_data  out  8  ASCII byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready
- busy  out  1  frame in progress (state != IDLE)

## Operation
- Frame for requester k has W+3 bytes:
  - tag byte 8'h41+k ('A'+k)
  - separator 8'h3A (':')
  - W bit characters, MSB first; bit 1 is 8'h31, bit 0 is 8'h30
  - end-of-line byte 8'h0A
- FSM states: IDLE, TAG, SEP, BITS, EOL.
  - IDLE -> TAG on a rising edge where any req bit is high. At that edge the block picks a winner, captures its field into a W-bit shift register, sets ack[winner], and updates the round-robin pointer.
  - TAG -> SEP, SEP -> BITS and EOL -> IDLE each advance on a byte acceptance.
  - BITS stays put for W acceptances. A bit counter runs 0..W-1, and the captured field shifts left after each accepted bit. On the W-th acceptance the FSM goes to EOL.
- Round-robin arbitration:
  - The pointer holds the last winner; the search starts at last+1 mod NREQ.
  - Reset value of the pointer is NREQ-1, so requester 0 has first priority after reset.
  - With a single request, that requester wins regardless of the pointer.
- Requests are sampled only in IDLE. A req that drops before it is granted is never served and never acked.
- The field is captured at grant time. Changes to data or req[k] after ack do not affect the frame in flight.
- A requester holding req high after its ack is treated as a new request and queues behind the others under round-robin.

## Timing
- Reset values: ack=0, tx_valid=0, tx_data=8'h00, busy=0, state=IDLE, pointer=NREQ-1, shift register and counter 0.
- Reset is asynchronous at any time, including mid-frame. The partial frame is dropped, there is no EOL, and no ack is reissued.
- Grant edge:
  - ack is high for exactly the one cycle after the grant edge.
  - In that same cycle tx_valid=1 with the tag byte, and busy=1.
- Bytes and backpressure:
  - tx_valid stays high continuously from TAG through EOL.
  - While tx_valid && !tx_ready, tx_data and all state hold stable.
- Throughput:
  - With tx_ready tied high, one byte is accepted per cycle, so a frame occupies W+3 cycles.
  - After the EOL acceptance there is one IDLE cycle (tx_valid=0, busy=0) before the next grant edge.
  - Frame-to-frame period is W+4 cycles.
- Latency: a request arriving in IDLE gets its tag byte on tx_data in the cycle after the next rising edge.

## Test plan
- Single request, NREQ=4, W=3, data[0 +: 3]=3'b101, tx_ready=1 -> ack=4'b0001 for one cycle, then tx_data 41, 3A, 31, 30, 31, 0A on six consecutive cycles, then busy=0.
- All four req held high, tx_ready=1 -> tags in the order 41, 42, 43, 44, 41. Each frame is 6 bytes, with one idle cycle between frames, and ack is one-hot per grant.
- Backpressure: requester 2 with data 3'b011, tx_ready toggling 1,0,0,1,... -> accepted byte sequence 43 3A 30 31 31 0A exactly. tx_data is unchanged across every stalled cycle, and no byte is duplicated or dropped.
- Capture isolation: data[1] changes from 3'b111 to 3'b000 the cycle after ack[1] -> frame emits 42 3A 31 31 31 0A.
- Reset mid-frame: rst_n low during BITS -> outputs go to reset values immediately. After release, with req[3] high, the first byte is 44 and the frame is complete.
- Withdrawn request: req[2] pulses high only during a frame belonging to requester 0 -> requester 2 is never acked and no tag 43 appears.
